// File: rtl/comparator_sweep.sv
// Drives an arithmetic sweep of operand pairs into an external comparator and
// tallies the flags it returns, counting any pair whose flags are not one-hot correct.
module comparator_sweep #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic [WIDTH-1:0] a_step,
  input  logic [WIDTH-1:0] b_step,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             aeqb,
  input  logic             agtb,
  input  logic             altb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] a_step_q;
  logic [WIDTH-1:0] b_step_q;
  logic [2:0]       expected;
  logic [2:0]       observed;
  logic             mismatch;

  // Reference result for the pair currently on a/b, ordered {eq, gt, lt}.
  always_comb begin
    expected = {a == b, a > b, a < b};
    observed = {aeqb, agtb, altb};
    mismatch = (observed != expected);
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      num_q    <= '0;
      idx      <= '0;
      a_step_q <= '0;
      b_step_q <= '0;
      a        <= '0;
      b        <= '0;
      eq_cnt   <= '0;
      gt_cnt   <= '0;
      lt_cnt   <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_q    <= num_pairs;
            a_step_q <= a_step;
            b_step_q <= b_step;
            a        <= '0;
            b        <= '0;
            idx      <= '0;
            eq_cnt   <= '0;
            gt_cnt   <= '0;
            lt_cnt   <= '0;
            err_cnt  <= '0;
            state    <= (num_pairs == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // A pair with several flags raised bumps every matching category.
          eq_cnt  <= eq_cnt + CNT_W'(aeqb);
          gt_cnt  <= gt_cnt + CNT_W'(agtb);
          lt_cnt  <= lt_cnt + CNT_W'(altb);
          err_cnt <= err_cnt + CNT_W'(mismatch);
          a       <= a + a_step_q;
          b       <= b + b_step_q;
          idx     <= idx + 1'b1;
          if (idx == num_q - 1'b1) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweep.sv
// Directed bench for comparator_sweep: an ideal comparator model with fault
// overrides feeds the flags back while each sweep's timing and tallies are checked.
module tb_comparator_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] num_pairs = '0;
  logic [3:0] a_step = '0;
  logic [3:0] b_step = '0;
  logic [3:0] a;
  logic [3:0] b;
  logic       aeqb;
  logic       agtb;
  logic       altb;
  logic       busy;
  logic       done;
  logic [5:0] eq_cnt;
  logic [5:0] gt_cnt;
  logic [5:0] lt_cnt;
  logic [5:0] err_cnt;

  logic force_eq1 = 1'b0;
  logic force_gt0 = 1'b0;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cycles;

  comparator_sweep dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pairs(num_pairs),
    .a_step(a_step), .b_step(b_step), .a(a), .b(b),
    .aeqb(aeqb), .agtb(agtb), .altb(altb), .busy(busy), .done(done),
    .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Ideal unsigned comparator, with optional stuck-at overrides.
  assign aeqb = force_eq1 ? 1'b1 : (a == b);
  assign agtb = force_gt0 ? 1'b0 : (a > b);
  assign altb = (a < b);

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Launch a sweep from a negedge; returns the number of busy cycles seen,
  // leaving time at the negedge where the design should be in DONE.
  task automatic sweep(input logic [5:0] n, input logic hold, output int busy_cycles);
    start     = 1'b1;
    num_pairs = n;
    a_step    = 4'd1;
    b_step    = 4'd2;
    @(negedge clk);
    if (!hold) start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic check_counts(input string tag, input int e, input int g, input int l, input int r);
    check({tag, "_eq"}, int'(eq_cnt), e);
    check({tag, "_gt"}, int'(gt_cnt), g);
    check({tag, "_lt"}, int'(lt_cnt), l);
    check({tag, "_err"}, int'(err_cnt), r);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check_counts("rst", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Ideal comparator, 16 pairs: one equal, eight greater, seven less.
    sweep(6'd16, 1'b0, cycles);
    check("ideal_busy_cycles", cycles, 16);
    check("ideal_done", int'(done), 1);
    check("ideal_done_busy", int'(busy), 0);
    check_counts("ideal", 1, 8, 7, 0);
    @(negedge clk);
    check("ideal_done_pulse", int'(done), 0);
    check_counts("ideal_hold", 1, 8, 7, 0);

    // Zero pairs goes straight to DONE and clears the previous tallies.
    sweep(6'd0, 1'b0, cycles);
    check("zero_busy_cycles", cycles, 0);
    check("zero_done", int'(done), 1);
    check_counts("zero", 0, 0, 0, 0);
    @(negedge clk);

    force_gt0 = 1'b1;
    sweep(6'd16, 1'b0, cycles);
    check("gt0_busy_cycles", cycles, 16);
    check_counts("gt0", 1, 0, 7, 8);
    force_gt0 = 1'b0;
    @(negedge clk);

    force_eq1 = 1'b1;
    sweep(6'd16, 1'b0, cycles);
    check("eq1_busy_cycles", cycles, 16);
    check_counts("eq1", 16, 8, 7, 15);
    force_eq1 = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a sweep, away from any clock edge.
    start = 1'b1;
    num_pairs = 6'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_a", int'(a), 0);
    check("mid_rst_b", int'(b), 0);
    check_counts("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(6'd16, 1'b0, cycles);
    check("post_rst_busy_cycles", cycles, 16);
    check("post_rst_done", int'(done), 1);
    check_counts("post_rst", 1, 8, 7, 0);
    @(negedge clk);

    // start held high: ignored in RUN/DONE, relaunches from the IDLE cycle after DONE.
    sweep(6'd16, 1'b1, cycles);
    check("hold_busy_cycles", cycles, 16);
    check("hold_done", int'(done), 1);
    check_counts("hold1", 1, 8, 7, 0);
    @(negedge clk);
    check("hold_idle_busy", int'(busy), 0);
    check("hold_idle_done", int'(done), 0);
    sweep(6'd16, 1'b0, cycles);
    check("hold2_busy_cycles", cycles, 16);
    check("hold2_done", int'(done), 1);
    check_counts("hold2", 1, 8, 7, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/comparator_sweep.md
COMPARATOR_SWEEP -- requirements
Module: comparator_sweep

Interface
REQ-001 Parameter WIDTH, default 4, operand width driven to the comparator.
REQ-002 Parameter CNT_W, default 6, width of the pair count and of all result counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 num_pairs  input  CNT_W  number of operand pairs to evaluate; latched on accepted start.
REQ-007 a_step  input  WIDTH  increment applied to a per pair; latched on accepted start.
REQ-008 b_step  input  WIDTH  increment applied to b per pair; latched on accepted start.
REQ-009 a  output  WIDTH  registered operand A to the downstream comparator.
REQ-010 b  output  WIDTH  registered operand B to the downstream comparator.
REQ-011 aeqb, agtb, altb  input  1 each  combinational comparator result for the current a, b.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse at sweep end.
REQ-014 eq_cnt, gt_cnt, lt_cnt  output  CNT_W each  count of pairs with aeqb, agtb, altb observed high, respectively.
REQ-015 err_cnt  output  CNT_W  count of pairs whose observed {aeqb,agtb,altb} differs from the expected one-hot result.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE on reset.
REQ-017 IDLE + start=1 SHALL latch num_pairs/a_step/b_step, clear all four counters, set a=0, b=0, set pair index=0, and go to RUN; if num_pairs=0, go directly to DONE instead.
REQ-018 IDLE + start=0: hold; a, b, and counters retain their values.
REQ-019 Each RUN cycle evaluates exactly one pair: at the closing edge, sample the three flags, update counters, a<=a+a_step, b<=b+b_step, index<=index+1.
REQ-020 a and b wrap modulo 2^WIDTH; no saturation or carry-out.
REQ-021 Expected result, unsigned: a==b -> 100, a>b -> 010, a<b -> 001 (order aeqb, agtb, altb).
REQ-022 A pair with multiple flags high SHALL increment each corresponding category counter and err_cnt once.
REQ-023 RUN -> DONE at the edge that evaluates pair num_pairs-1; N pairs occupy exactly N RUN cycles.
REQ-024 DONE lasts one cycle with done=1, busy=0, then returns to IDLE unconditionally.
REQ-025 start is ignored in RUN and DONE; a start high in the first IDLE cycle after DONE begins a new sweep.
REQ-026 Counters hold final values from DONE until the next accepted start.
REQ-027 Counters cannot overflow, since pairs <= 2^CNT_W-1; no wrap handling is required.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, a=0, b=0, busy=0, done=0, and all counters to 0, including mid-RUN.
REQ-029 After rst_n deasserts, the first accepted start is the earliest possible at the next rising edge.

Verification
REQ-030 Ideal comparator, a_step=1, b_step=2, num_pairs=16, start pulse -> busy for 16 cycles, done one cycle later, eq_cnt=1, gt_cnt=8, lt_cnt=7, err_cnt=0.
REQ-031 num_pairs=0, start pulse -> done high the cycle after start, busy never high, all counters 0.
REQ-032 Same as REQ-030 with agtb forced 0 -> gt_cnt=0, eq_cnt=1, lt_cnt=7, err_cnt=8.
REQ-033 Same as REQ-030 with aeqb forced 1 -> eq_cnt=16, gt_cnt=8, lt_cnt=7, err_cnt=15.
REQ-034 rst_n pulsed low after 5 RUN cycles -> a=0, b=0, counters 0, busy=0 without waiting for a clock edge; a subsequent sweep matches REQ-030.
REQ-035 start held high through a REQ-030 sweep -> RUN lasts exactly 16 cycles; a second sweep starts in the IDLE cycle after DONE and yields identical counts.
